// File: rtl/dual_issue_dispatch.sv
// -----------------------------------------------------------------------------
// dual_issue_dispatch
//
// Dispatch stage that sits right after the issue queue's pairwise RAW/WAR
// hazard checker. Each cycle it may accept a candidate pair: slot A is the
// older instruction and slot B the younger one.
//   - Independent pair: both instructions go out together in one cycle.
//   - Hazardous pair (hazard_flag=1 with B valid): A goes out first. B is
//     parked in a hold register and goes out alone once the output register
//     is free again. Each split bumps a saturating counter.
// The output is a registered two-slot issue bundle with a valid/ready
// handshake toward the execute stage. No combinational path runs from in_*
// to out_*. in_ready depends only on the FSM state, out_v0 and out_ready.
//
// Ports
//   clk, rst                         clock; synchronous active-high reset
//   in_valid / in_v2                 slot A / slot B candidate valid
//   in_op1, in_des1, in_s11, in_s12  slot A fields (des 0 = no writeback)
//   in_op2, in_des2, in_s21, in_s22  slot B fields
//   hazard_flag                      checker verdict for the presented pair
//   in_ready                         pair is accepted this cycle if in_valid
//   out_ready                        execute stage accepts the output bundle
//   out_v0, out_op0 .. out_s02       issue slot 0 (always the older one)
//   out_v1, out_op1 .. out_s12       issue slot 1
//   split_cnt                        saturating count of split pairs
// -----------------------------------------------------------------------------
module dual_issue_dispatch #(
  parameter int DES_W = 4,
  parameter int SRC_W = 4,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_v2,
  input  logic [OP_W-1:0]  in_op1,
  input  logic [DES_W-1:0] in_des1,
  input  logic [SRC_W-1:0] in_s11,
  input  logic [SRC_W-1:0] in_s12,
  input  logic [OP_W-1:0]  in_op2,
  input  logic [DES_W-1:0] in_des2,
  input  logic [SRC_W-1:0] in_s21,
  input  logic [SRC_W-1:0] in_s22,
  input  logic             hazard_flag,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_v0,
  output logic [OP_W-1:0]  out_op0,
  output logic [DES_W-1:0] out_des0,
  output logic [SRC_W-1:0] out_s01,
  output logic [SRC_W-1:0] out_s02,
  output logic             out_v1,
  output logic [OP_W-1:0]  out_op1,
  output logic [DES_W-1:0] out_des1,
  output logic [SRC_W-1:0] out_s11,
  output logic [SRC_W-1:0] out_s12,
  output logic [CNT_W-1:0] split_cnt
);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [DES_W-1:0] des;
    logic [SRC_W-1:0] s1;
    logic [SRC_W-1:0] s2;
  } insn_t;

  typedef enum logic {
    PAIR = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  insn_t            slot0_q, slot0_d;
  insn_t            slot1_q, slot1_d;
  insn_t            hold_q,  hold_d;
  logic             v0_q,    v0_d;
  logic             v1_q,    v1_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  insn_t insn_a;
  insn_t insn_b;
  logic  out_free;
  logic  accept;
  logic  split;

  assign insn_a = {in_op1, in_des1, in_s11, in_s12};
  assign insn_b = {in_op2, in_des2, in_s21, in_s22};

  // The output register can take new contents when it is empty or is being
  // drained this cycle.
  assign out_free = !v0_q || out_ready;
  assign in_ready = (state_q == PAIR) && out_free;
  assign accept   = in_valid && in_ready;
  // hazard_flag only matters for an accepted pair with B present. Gating it
  // here keeps an X on the flag from leaking into state otherwise.
  assign split    = accept && in_v2 && hazard_flag;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    hold_d  = hold_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    cnt_d   = cnt_q;

    case (state_q)
      PAIR: begin
        if (accept) begin
          slot0_d = insn_a;
          v0_d    = 1'b1;
          if (split) begin
            slot1_d = '0;
            v1_d    = 1'b0;
            hold_d  = insn_b;
            state_d = HOLD;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          end else begin
            slot1_d = insn_b;
            v1_d    = in_v2;
          end
        end else if (out_ready) begin
          // The bundle was consumed and nothing replaces it: emit a bubble.
          v0_d = 1'b0;
          v1_d = 1'b0;
        end
      end

      HOLD: begin
        // The younger half of a split pair goes out alone in slot 0.
        if (out_free) begin
          slot0_d = hold_q;
          v0_d    = 1'b1;
          slot1_d = '0;
          v1_d    = 1'b0;
          state_d = PAIR;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the hold register is cleared as well, so a pair split before
      // reset leaves no stale instruction behind.
      state_q <= PAIR;
      slot0_q <= '0;
      slot1_q <= '0;
      hold_q  <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from the
      // values that were present before the edge.
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      hold_q  <= hold_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_v0    = v0_q;
  assign out_op0   = slot0_q.op;
  assign out_des0  = slot0_q.des;
  assign out_s01   = slot0_q.s1;
  assign out_s02   = slot0_q.s2;
  assign out_v1    = v1_q;
  assign out_op1   = slot1_q.op;
  assign out_des1  = slot1_q.des;
  assign out_s11   = slot1_q.s1;
  assign out_s12   = slot1_q.s2;
  assign split_cnt = cnt_q;

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_dispatch
//
// Directed scenarios followed by a randomized phase. A behavioural model
// tracks what must be sitting in the issue slots. A program-order scoreboard
// checks that every consumed instruction is the next one the stage accepted.
// The counter is built narrow so that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_dual_issue_dispatch;

  localparam int DES_W   = 4;
  localparam int SRC_W   = 4;
  localparam int OP_W    = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [DES_W-1:0] des;
    logic [SRC_W-1:0] s1;
    logic [SRC_W-1:0] s2;
  } insn_t;

  logic             clk;
  logic             rst;
  logic             in_valid, in_v2, hazard_flag, in_ready, out_ready;
  logic [OP_W-1:0]  in_op1, in_op2, out_op0, out_op1;
  logic [DES_W-1:0] in_des1, in_des2, out_des0, out_des1;
  logic [SRC_W-1:0] in_s11, in_s12, in_s21, in_s22;
  logic [SRC_W-1:0] out_s01, out_s02, out_s11, out_s12;
  logic             out_v0, out_v1;
  logic [CNT_W-1:0] split_cnt;

  dual_issue_dispatch #(
    .DES_W(DES_W), .SRC_W(SRC_W), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_v2(in_v2),
    .in_op1(in_op1), .in_des1(in_des1), .in_s11(in_s11), .in_s12(in_s12),
    .in_op2(in_op2), .in_des2(in_des2), .in_s21(in_s21), .in_s22(in_s22),
    .hazard_flag(hazard_flag), .in_ready(in_ready), .out_ready(out_ready),
    .out_v0(out_v0), .out_op0(out_op0), .out_des0(out_des0),
    .out_s01(out_s01), .out_s02(out_s02),
    .out_v1(out_v1), .out_op1(out_op1), .out_des1(out_des1),
    .out_s11(out_s11), .out_s12(out_s12),
    .split_cnt(split_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  insn_t o0, o1;
  assign o0 = {out_op0, out_des0, out_s01, out_s02};
  assign o1 = {out_op1, out_des1, out_s11, out_s12};

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: what the issue slots must hold, the instruction still
  // waiting to go out alone, and the program-order stream of accepted work.
  logic  m_v0 = 1'b0;
  logic  m_v1 = 1'b0;
  insn_t m_s0 = '0;
  insn_t m_s1 = '0;
  insn_t m_wait[$];
  int    m_cnt = 0;
  insn_t prog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic insn_t mk(input int op, input int des, input int s1, input int s2);
    insn_t r;
    r.op  = op[OP_W-1:0];
    r.des = des[DES_W-1:0];
    r.s1  = s1[SRC_W-1:0];
    r.s2  = s2[SRC_W-1:0];
    return r;
  endfunction

  function automatic insn_t rnd_insn();
    return insn_t'($urandom_range(0, 16'hffff));
  endfunction

  // One clock cycle: drive inputs, check in_ready and the consumed stream
  // before the edge, advance the model, then check the registered outputs.
  task automatic step(input logic v, input logic v2, input insn_t a, input insn_t b,
                      input logic hz, input logic ordy, input logic r);
    logic  free;
    logic  ready;
    insn_t e;
    in_valid = v;
    in_v2    = v2;
    {in_op1, in_des1, in_s11, in_s12} = a;
    {in_op2, in_des2, in_s21, in_s22} = b;
    hazard_flag = hz;
    out_ready   = ordy;
    rst         = r;
    #1;
    free  = !m_v0 || ordy;
    ready = (m_wait.size() == 0) && free;
    if (!r) begin
      check("in_ready", in_ready, ready);
      if (out_v0 && ordy) begin
        e = (prog.size() > 0) ? prog.pop_front() : 'x;
        check("order_slot0", o0, e);
        if (out_v1) begin
          e = (prog.size() > 0) ? prog.pop_front() : 'x;
          check("order_slot1", o1, e);
        end
      end
    end
    if (r) begin
      m_v0 = 1'b0; m_v1 = 1'b0; m_cnt = 0;
      m_wait.delete();
      prog.delete();
    end else if (free) begin
      if (m_wait.size() > 0) begin
        m_s0 = m_wait.pop_front();
        m_v0 = 1'b1;
        m_v1 = 1'b0;
      end else if (v) begin
        prog.push_back(a);
        if (v2) prog.push_back(b);
        m_s0 = a;
        m_v0 = 1'b1;
        if (v2 && hz) begin
          m_wait.push_back(b);
          m_v1  = 1'b0;
          m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else begin
          m_s1 = b;
          m_v1 = v2;
        end
      end else begin
        m_v0 = 1'b0;
        m_v1 = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_v0", out_v0, m_v0);
    check("out_v1", out_v1, m_v1);
    check("split_cnt", split_cnt, m_cnt);
    check("v1_implies_v0", !out_v1 || out_v0, 1'b1);
    if (m_v0) check("slot0", o0, m_s0);
    if (m_v1) check("slot1", o1, m_s1);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, '0, 1'bx, ordy, 1'b0);
  endtask

  initial begin
    insn_t a, b, held;
    int    issued;

    // Reset held for two cycles while a pair is presented.
    a = mk(1, 3, 1, 2);
    b = mk(2, 5, 6, 7);
    step(1'b1, 1'b1, a, b, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, a, b, 1'b0, 1'b1, 1'b1);
    check("rst_v0", out_v0, 1'b0);
    check("rst_v1", out_v1, 1'b0);
    check("rst_cnt", split_cnt, '0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Independent pair issues together.
    step(1'b1, 1'b1, a, b, 1'b0, 1'b1, 1'b0);
    check("indep_v1", out_v1, 1'b1);
    check("indep_des0", out_des0, 4'd3);
    check("indep_des1", out_des1, 4'd5);
    check("indep_cnt", split_cnt, '0);

    // Hazard split: A alone, then B alone.
    a = mk(3, 3, 1, 2);
    b = mk(4, 8, 3, 9);
    step(1'b1, 1'b1, a, b, 1'b1, 1'b1, 1'b0);
    check("split_a_des", out_des0, 4'd3);
    check("split_a_v1", out_v1, 1'b0);
    check("split_in_ready", in_ready, 1'b0);
    check("split_cnt1", split_cnt, 2'd1);
    idle(1'b1);
    check("split_b_des", out_des0, 4'd8);
    check("split_b_v1", out_v1, 1'b0);
    idle(1'b1);

    // Backpressure while holding B: A stays put, B follows the ready edge.
    a = mk(5, 10, 11, 12);
    b = mk(6, 13, 10, 14);
    step(1'b1, 1'b1, a, b, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("bp_hold_a", o0, a);
    end
    idle(1'b1);
    check("bp_b_issued", o0, b);
    idle(1'b1);

    // Streaming: eight independent pairs back to back.
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, mk(i, 2 * i, i + 1, i + 2), mk(i + 8, 2 * i + 1, i + 3, i + 4),
           1'b0, 1'b1, 1'b0);
      issued += int'(out_v0) + int'(out_v1);
    end
    check("stream_count", issued, 16);
    idle(1'b1);

    // Counter saturation after five splits.
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, mk(7, 1, 2, 3), mk(8, 4, 1, 5), 1'b1, 1'b1, 1'b0);
      idle(1'b1);
    end
    check("sat_cnt", split_cnt, 2'd3);

    // Reset while in HOLD discards the held instruction.
    held = mk(9, 15, 15, 15);
    step(1'b1, 1'b1, mk(10, 2, 3, 4), held, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("hold_rst_v0", out_v0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("held_never_seen", out_v0 && (o0 == held), 1'b0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic v, v2, hz, ordy, r;
      v    = ($urandom_range(0, 3) != 0);
      v2   = $urandom_range(0, 1) != 0;
      hz   = v2 ? ($urandom_range(0, 2) == 0) : 1'bx;
      ordy = ($urandom_range(0, 3) != 0);
      r    = ($urandom_range(0, 49) == 0);
      step(v, v2, rnd_insn(), rnd_insn(), hz, ordy, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
